// File: rtl/debounce_pkg.sv
// Shared types and limits for the input debouncer and its synchroniser.
package debounce_pkg;

  typedef enum logic {ST_STABLE, ST_QUALIFY} db_state_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/sync_chain.sv
// Generic multi-flop synchroniser for a single asynchronous bit; no logic in the path.
module sync_chain #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= {STAGES{RESET_LEVEL}};
    end else begin
      ff <= {ff[STAGES-2:0], din};
    end
  end

  assign dout = ff[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Debouncer: synchronise an async input, then accept a level change only after
// STABLE_CYCLES consecutive mismatching edges; emits registered edge pulses.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   CNT_W         = 16,
  parameter int   STABLE_CYCLES = 50000,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_async,
  output logic dout,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  generate
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("debounce_sync: SYNC_STAGES out of range");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_small
      $error("debounce_sync: STABLE_CYCLES must be at least 2");
    end
    if (longint'(STABLE_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_large
      $error("debounce_sync: STABLE_CYCLES does not fit in CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync_out;
  logic             mismatch;
  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dout_nxt, rise_nxt, fall_nxt;

  sync_chain #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din_async),
    .dout  (sync_out)
  );

  assign mismatch = (sync_out != dout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_STABLE;
      cnt        <= '0;
      dout       <= RESET_LEVEL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dout       <= dout_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

  // A bounce back to the current level abandons the candidate without any output effect.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dout_nxt  = dout;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      ST_STABLE: begin
        if (mismatch) begin
          cnt_nxt   = CNT_W'(1);
          state_nxt = ST_QUALIFY;
        end else begin
          cnt_nxt = '0;
        end
      end
      ST_QUALIFY: begin
        if (!mismatch) begin
          cnt_nxt   = '0;
          state_nxt = ST_STABLE;
        end else if (cnt == CNT_LAST) begin
          dout_nxt  = ~dout;
          rise_nxt  = ~dout;
          fall_nxt  = dout;
          cnt_nxt   = '0;
          state_nxt = ST_STABLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_STABLE;
      end
    endcase
  end

  assign busy = (state == ST_QUALIFY);

endmodule

// File: tb/tb_debounce_sync.sv
// Randomised and directed bench for debounce_sync against a run-length reference model.
module tb_debounce_sync;

  localparam int   SYNC_STAGES   = 2;
  localparam int   CNT_W         = 4;
  localparam int   STABLE_CYCLES = 4;
  localparam logic RESET_LEVEL   = 1'b0;

  logic clk;
  logic rst_n;
  logic din_async;
  logic dout;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  debounce_sync #(
    .SYNC_STAGES   (SYNC_STAGES),
    .CNT_W         (CNT_W),
    .STABLE_CYCLES (STABLE_CYCLES),
    .RESET_LEVEL   (RESET_LEVEL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_async  (din_async),
    .dout       (dout),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: input seen SYNC_STAGES edges late; dout flips once a run of
  // STABLE_CYCLES consecutive edges has seen a value different from dout.
  logic exp_q[$];
  logic m_dout, m_rise, m_fall, m_busy;
  int   m_run;

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < SYNC_STAGES; i++) exp_q.push_back(RESET_LEVEL);
    m_dout = RESET_LEVEL;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_busy = 1'b0;
    m_run  = 0;
  endtask

  task automatic model_edge(input logic d);
    logic seen;
    seen = exp_q.pop_front();
    exp_q.push_back(d);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (seen != m_dout) begin
      m_run = m_run + 1;
      if (m_run == STABLE_CYCLES) begin
        m_dout = ~m_dout;
        m_rise = m_dout;
        m_fall = ~m_dout;
        m_run  = 0;
      end
    end else begin
      m_run = 0;
    end
    m_busy = (m_run > 0);
  endtask

  // per-phase observations of the DUT
  int step_idx, first_busy, first_rise, first_fall, rise_cnt, fall_cnt;

  task automatic start_phase();
    step_idx   = 0;
    first_busy = -1;
    first_rise = -1;
    first_fall = -1;
    rise_cnt   = 0;
    fall_cnt   = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".dout"}, 32'(dout), 32'(m_dout));
    check_eq({tag, ".rise"}, 32'(rise_pulse), 32'(m_rise));
    check_eq({tag, ".fall"}, 32'(fall_pulse), 32'(m_fall));
    check_eq({tag, ".busy"}, 32'(busy), 32'(m_busy));
    check_eq({tag, ".both_pulses"}, 32'(rise_pulse & fall_pulse), 32'(0));
  endtask

  // driver: apply din for one edge, then compare after the edge
  task automatic step(input logic d, input string tag);
    din_async = d;
    @(posedge clk);
    model_edge(d);
    #1;
    check_outputs(tag);
    if (busy && first_busy < 0) first_busy = step_idx;
    if (rise_pulse) begin
      rise_cnt++;
      if (first_rise < 0) first_rise = step_idx;
    end
    if (fall_pulse) begin
      fall_cnt++;
      if (first_fall < 0) first_fall = step_idx;
    end
    step_idx++;
  endtask

  task automatic hold(input logic d, input int n, input string tag);
    for (int i = 0; i < n; i++) step(d, tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    din_async = 1'b1;
    model_reset();

    // 1: input high through reset, then qualified after release
    @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    start_phase();
    hold(1'b1, 8, "t1");
    check_eq("t1.rise_edge", 32'(first_rise), 32'(SYNC_STAGES + STABLE_CYCLES - 1));
    check_eq("t1.rise_cnt", 32'(rise_cnt), 32'(1));

    // 4: falling change
    start_phase();
    hold(1'b0, 8, "t4");
    check_eq("t4.fall_edge", 32'(first_fall), 32'(5));
    check_eq("t4.rise_cnt", 32'(rise_cnt), 32'(0));
    check_eq("t4.dout", 32'(dout), 32'(0));

    // 3: bounce shorter than the qualify window
    start_phase();
    hold(1'b1, 3, "t3");
    hold(1'b0, 6, "t3");
    check_eq("t3.pulses", 32'(rise_cnt + fall_cnt), 32'(0));
    check_eq("t3.busy_seen", 32'(first_busy >= 0), 32'(1));
    check_eq("t3.dout", 32'(dout), 32'(0));

    // 2: clean rising change, busy and pulse timing
    start_phase();
    hold(1'b1, 8, "t2");
    check_eq("t2.busy_edge", 32'(first_busy), 32'(2));
    check_eq("t2.rise_edge", 32'(first_rise), 32'(5));
    check_eq("t2.rise_cnt", 32'(rise_cnt), 32'(1));

    // 6: run of 3, gap, run of 4+ -> only the last run qualifies
    hold(1'b0, 8, "t6.prep");
    start_phase();
    hold(1'b1, 3, "t6");
    hold(1'b0, 1, "t6");
    hold(1'b1, 8, "t6");
    check_eq("t6.rise_cnt", 32'(rise_cnt), 32'(1));
    check_eq("t6.rise_edge", 32'(first_rise), 32'(4 + SYNC_STAGES + STABLE_CYCLES - 1));

    // 5: reset while qualifying a falling change
    start_phase();
    hold(1'b0, 4, "t5");
    check_eq("t5.busy_pre", 32'(busy), 32'(1));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("t5.async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    start_phase();
    hold(1'b0, 8, "t5.post");
    check_eq("t5.post_pulses", 32'(rise_cnt + fall_cnt), 32'(0));

    // random runs of varying length
    start_phase();
    for (int r = 0; r < 60; r++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      hold(v, len, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
